// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu core: field widths, opcodes, FSM encoding.
package cpu_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int OP_W   = 5;
  localparam int REG_W  = 3;

  localparam logic [OP_W-1:0] OP_NOP   = 5'b00000;
  localparam logic [OP_W-1:0] OP_HALT  = 5'b00001;
  localparam logic [OP_W-1:0] OP_LOAD  = 5'b00010;
  localparam logic [OP_W-1:0] OP_STORE = 5'b00011;
  localparam logic [OP_W-1:0] OP_ADD   = 5'b01000;
  localparam logic [OP_W-1:0] OP_ADDI  = 5'b01001;
  localparam logic [OP_W-1:0] OP_SUB   = 5'b01010;
  localparam logic [OP_W-1:0] OP_AND   = 5'b01100;
  localparam logic [OP_W-1:0] OP_OR    = 5'b01101;
  localparam logic [OP_W-1:0] OP_XOR   = 5'b01110;
  localparam logic [OP_W-1:0] OP_SLL   = 5'b10000;
  localparam logic [OP_W-1:0] OP_SRL   = 5'b10001;

  localparam logic [DATA_W-1:0] IR_NOP  = {OP_NOP, 11'b0};
  localparam logic [ADDR_W-1:0] PC_STEP = 8'd1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  function automatic logic op_writes_back(input logic [OP_W-1:0] op);
    case (op)
      OP_LOAD, OP_ADD, OP_ADDI, OP_SUB, OP_AND,
      OP_OR, OP_XOR, OP_SLL, OP_SRL: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

  function automatic logic op_uses_r3(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/cpu_alu.sv
// Combinational EX-stage ALU; also forms LOAD/STORE addresses (a + b).
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [OP_W-1:0]   i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_y
);
  always_comb begin
    o_y = '0;
    case (i_op)
      OP_ADD, OP_ADDI, OP_LOAD, OP_STORE: o_y = i_a + i_b;
      OP_SUB: o_y = i_a - i_b;
      OP_AND: o_y = i_a & i_b;
      OP_OR:  o_y = i_a | i_b;
      OP_XOR: o_y = i_a ^ i_b;
      OP_SLL: o_y = i_a << i_b[3:0];
      OP_SRL: o_y = i_a >> i_b[3:0];
      default: o_y = '0;
    endcase
  end
endmodule

// File: rtl/cpu.sv
// 5-stage in-order 16-bit core, no interlocks. CPU_ZERO_REG_EN hardwires gr0 to zero.
// state   | meaning
// ST_IDLE | fetch stalled, NOPs injected, older instructions drain
// ST_EXEC | fetching from pc every enabled cycle until HALT reaches ID
module cpu
  import cpu_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              start,
  input  logic [DATA_W-1:0] i_datain,
  output logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] d_datain,
  output logic [ADDR_W-1:0] d_addr,
  output logic [DATA_W-1:0] d_dataout,
  output logic              d_we
);
  state_t r_state, w_state_nxt;

  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_id_ir;
  logic [DATA_W-1:0] r_reg_a, r_reg_b, r_reg_c, r_reg_c1;
  logic [DATA_W-1:0] r_st_ex, r_st_mem;
  logic [OP_W-1:0]   r_ex_op, r_mem_op, r_wb_op;
  logic [REG_W-1:0]  r_ex_r1, r_mem_r1, r_wb_r1;
  logic [DATA_W-1:0] r_gr [8];

  logic [OP_W-1:0]   w_op;
  logic [REG_W-1:0]  w_r1, w_r2, w_r3;
  logic [3:0]        w_val3;
  logic [7:0]        w_imm8;
  logic [DATA_W-1:0] w_gr_r1, w_gr_r2, w_gr_r3;
  logic [DATA_W-1:0] w_opa, w_opb, w_alu_y;
  logic              w_wb_en;

  assign w_op   = r_id_ir[15:11];
  assign w_r1   = r_id_ir[10:8];
  assign w_r2   = r_id_ir[6:4];
  assign w_r3   = r_id_ir[2:0];
  assign w_val3 = r_id_ir[3:0];
  assign w_imm8 = r_id_ir[7:0];

`ifdef CPU_ZERO_REG_EN
  assign w_gr_r1 = (w_r1 == '0) ? '0 : r_gr[w_r1];
  assign w_gr_r2 = (w_r2 == '0) ? '0 : r_gr[w_r2];
  assign w_gr_r3 = (w_r3 == '0) ? '0 : r_gr[w_r3];
  assign w_wb_en = op_writes_back(r_wb_op) && (r_wb_r1 != '0);
`else
  assign w_gr_r1 = r_gr[w_r1];
  assign w_gr_r2 = r_gr[w_r2];
  assign w_gr_r3 = r_gr[w_r3];
  assign w_wb_en = op_writes_back(r_wb_op);
`endif

  always_comb begin
    w_opa = (w_op == OP_ADDI) ? w_gr_r1 : w_gr_r2;
    if (op_uses_r3(w_op))
      w_opb = w_gr_r3;
    else if (w_op == OP_ADDI)
      w_opb = {8'b0, w_imm8};
    else
      w_opb = {12'b0, w_val3};
  end

  cpu_alu u_alu (
    .i_op (r_ex_op),
    .i_a  (r_reg_a),
    .i_b  (r_reg_b),
    .o_y  (w_alu_y)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_EXEC;
      ST_EXEC: if (w_op == OP_HALT) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset)       r_state <= ST_IDLE;
    else if (enable) r_state <= w_state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc     <= '0;
      r_id_ir  <= IR_NOP;
      r_reg_a  <= '0;
      r_reg_b  <= '0;
      r_reg_c  <= '0;
      r_reg_c1 <= '0;
      r_st_ex  <= '0;
      r_st_mem <= '0;
      r_ex_op  <= OP_NOP;
      r_mem_op <= OP_NOP;
      r_wb_op  <= OP_NOP;
      r_ex_r1  <= '0;
      r_mem_r1 <= '0;
      r_wb_r1  <= '0;
      for (int i = 0; i < 8; i++) r_gr[i] <= '0;
    end else if (enable) begin
      if (r_state == ST_EXEC) begin
        r_id_ir <= i_datain;
        r_pc    <= r_pc + PC_STEP;
      end else begin
        r_id_ir <= IR_NOP;
      end
      r_reg_a  <= w_opa;
      r_reg_b  <= w_opb;
      r_st_ex  <= w_gr_r1;
      r_ex_op  <= w_op;
      r_ex_r1  <= w_r1;
      r_reg_c  <= w_alu_y;
      r_st_mem <= r_st_ex;
      r_mem_op <= r_ex_op;
      r_mem_r1 <= r_ex_r1;
      r_reg_c1 <= (r_mem_op == OP_LOAD) ? d_datain : r_reg_c;
      r_wb_op  <= r_mem_op;
      r_wb_r1  <= r_mem_r1;
      // WB lands on the same edge ID samples, so the reader sees the old value
      if (w_wb_en) r_gr[r_wb_r1] <= r_reg_c1;
    end
  end

  assign i_addr    = r_pc;
  assign d_addr    = r_reg_c[ADDR_W-1:0];
  assign d_dataout = r_st_mem;
  assign d_we      = enable && (r_mem_op == OP_STORE);
endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: directed pipeline scenarios plus randomized
// programs checked against a sequential instruction-level model.
module tb_cpu;
  localparam logic [4:0] T_NOP = 5'b00000, T_HALT = 5'b00001, T_LOAD = 5'b00010;
  localparam logic [4:0] T_STORE = 5'b00011, T_ADD = 5'b01000, T_ADDI = 5'b01001;
  localparam logic [4:0] T_SUB = 5'b01010, T_AND = 5'b01100, T_OR = 5'b01101;
  localparam logic [4:0] T_XOR = 5'b01110, T_SLL = 5'b10000, T_SRL = 5'b10001;
  localparam logic [4:0] OPS [12] = '{T_ADD, T_ADDI, T_SUB, T_AND, T_OR, T_XOR,
                                      T_SLL, T_SRL, T_LOAD, T_STORE, 5'b10111, 5'b00101};

  logic        clock = 1'b0;
  logic        reset, enable, start;
  logic [15:0] i_datain, d_datain, d_dataout;
  logic [7:0]  i_addr, d_addr;
  logic        d_we;

  logic [15:0] imem [256];
  logic [15:0] dmem [256];
  logic [15:0] mm   [256];
  logic [15:0] mgr  [8];
  logic [23:0] exp_q [$];
  int          n_cmp = 0, n_err = 0, we_cnt = 0;

  always #5 clock = ~clock;

  assign i_datain = imem[i_addr];
  assign d_datain = dmem[d_addr];

  cpu dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .start     (start),
    .i_datain  (i_datain),
    .i_addr    (i_addr),
    .d_datain  (d_datain),
    .d_addr    (d_addr),
    .d_dataout (d_dataout),
    .d_we      (d_we)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observe the data bus mid-cycle (acting as data memory), then advance one edge.
  task automatic tick();
    logic [23:0] e;
    @(negedge clock);
    if (!enable) chk("we_stall", {31'b0, d_we}, 0);
    if (d_we === 1'b1) begin
      we_cnt++;
      chk("st_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("st_addr", {24'b0, d_addr}, {24'b0, e[23:16]});
        chk("st_data", {16'b0, d_dataout}, {16'b0, e[15:0]});
      end
      dmem[d_addr] = d_dataout;
    end
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] mrd(input logic [2:0] r);
`ifdef CPU_ZERO_REG_EN
    if (r == 3'd0) return 16'h0;
`endif
    return mgr[r];
  endfunction

  function automatic void mwr(input logic [2:0] r, input logic [15:0] v);
`ifdef CPU_ZERO_REG_EN
    if (r == 3'd0) return;
`endif
    mgr[r] = v;
  endfunction

  // One instruction with architectural (sequential) semantics.
  function automatic void mexec(input logic [15:0] ir);
    logic [4:0] op;
    logic [2:0] r1, r2, r3;
    int v3, imm, a, b, addr;
    op = ir[15:11]; r1 = ir[10:8]; r2 = ir[6:4]; r3 = ir[2:0];
    v3 = int'(ir[3:0]); imm = int'(ir[7:0]);
    a = int'(mrd(r2)); b = int'(mrd(r3));
    addr = (a + v3) % 256;
    case (op)
      T_LOAD:  mwr(r1, mm[addr]);
      T_STORE: begin
        mm[addr] = mrd(r1);
        exp_q.push_back({8'(addr), mrd(r1)});
      end
      T_ADD:  mwr(r1, 16'(a + b));
      T_ADDI: mwr(r1, 16'(int'(mrd(r1)) + imm));
      T_SUB:  mwr(r1, 16'(a - b + 65536));
      T_AND:  mwr(r1, 16'(a & b));
      T_OR:   mwr(r1, 16'(a | b));
      T_XOR:  mwr(r1, 16'(a ^ b));
      T_SLL:  mwr(r1, 16'(a << v3));
      T_SRL:  mwr(r1, 16'(a >> v3));
      default: ;
    endcase
  endfunction

  // The word after HALT is already fetched when HALT decodes, so it still runs.
  task automatic model_run(input logic [7:0] pc0, output logic [7:0] pc_end);
    logic [7:0] pc;
    pc = pc0;
    pc_end = pc0;
    for (int k = 0; k < 256; k++) begin
      if (imem[pc][15:11] == T_HALT) begin
        mexec(imem[pc + 8'd1]);
        pc_end = pc + 8'd2;
        break;
      end
      mexec(imem[pc]);
      pc = pc + 8'd1;
    end
  endtask

  function automatic logic [15:0] enc(input logic [4:0] op, input logic [2:0] r1,
                                      input logic [2:0] r2, input logic [3:0] v3);
    return {op, r1, 1'b0, r2, v3};
  endfunction

  task automatic do_reset();
    reset = 1'b1; enable = 1'b1; start = 1'b0;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) mgr[i] = 16'h0;
    exp_q.delete();
    we_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic run(input int n, input bit stall);
    for (int i = 0; i < n; i++) begin
      enable = stall ? ($urandom_range(0, 99) >= 15) : 1'b1;
      tick();
    end
    enable = 1'b1;
  endtask

  task automatic init_mem();
    for (int i = 0; i < 256; i++) begin
      dmem[i] = 16'($urandom());
      mm[i] = dmem[i];
      imem[i] = 16'h0000;
    end
  endtask

  task automatic set_mem(input int a, input logic [15:0] v);
    dmem[a] = v; mm[a] = v;
  endtask

  task automatic end_checks();
    chk("q_empty", exp_q.size(), 0);
    for (int i = 0; i < 256; i++) chk("dmem", {16'b0, dmem[i]}, {16'b0, mm[i]});
  endtask

  initial begin
    logic [7:0] pe, pe2;
    logic [4:0] op;
    logic [15:0] ir;
    int p;
    reset = 1'b1; enable = 1'b1; start = 1'b0;
    init_mem();

    // Load/add timing, reset state, idle hold
    set_mem(2, 16'h00AB); set_mem(1, 16'h3C00);
    imem[0] = enc(T_LOAD, 3'd1, 3'd0, 4'd2);
    imem[1] = enc(T_LOAD, 3'd2, 3'd0, 4'd1);
    imem[5] = enc(T_ADD, 3'd3, 3'd1, 4'd2);
    imem[9] = enc(T_STORE, 3'd1, 3'd0, 4'd8);
    imem[10] = enc(T_STORE, 3'd2, 3'd0, 4'd9);
    imem[11] = enc(T_STORE, 3'd3, 3'd0, 4'd10);
    imem[12] = {T_HALT, 11'b0};
    do_reset();
    chk("rst_pc", {24'b0, i_addr}, 0);
    chk("rst_we", {31'b0, d_we}, 0);
    chk("rst_daddr", {24'b0, d_addr}, 0);
    chk("rst_dout", {16'b0, d_dataout}, 0);
    tick(); tick(); tick();
    chk("idle_pc", {24'b0, i_addr}, 0);
    model_run(8'd0, pe);
    pulse_start();
    chk("fetch0", {24'b0, i_addr}, 0);
    tick();
    chk("fetch1", {24'b0, i_addr}, 1);
    tick(); tick();
    chk("ld1_addr", {24'b0, d_addr}, 8'h02);
    tick();
    chk("ld2_addr", {24'b0, d_addr}, 8'h01);
    run(40, 0);
    chk("gr1_val", {16'b0, dmem[8]}, 16'h00AB);
    chk("gr2_val", {16'b0, dmem[9]}, 16'h3C00);
    chk("add_res", {16'b0, dmem[10]}, 16'h3CAB);
    chk("halt_pc1", {24'b0, i_addr}, {24'b0, pe});
    end_checks();

    // Single store pulse, frozen across a 3-cycle enable drop
    init_mem();
    set_mem(3, 16'h1234);
    imem[0] = enc(T_LOAD, 3'd1, 3'd0, 4'd3);
    imem[4] = enc(T_STORE, 3'd1, 3'd0, 4'd5);
    imem[5] = {T_HALT, 11'b0};
    do_reset();
    model_run(8'd0, pe);
    pulse_start();
    repeat (7) tick();
    chk("st_we", {31'b0, d_we}, 1);
    chk("st_daddr", {24'b0, d_addr}, 8'h05);
    chk("st_dout", {16'b0, d_dataout}, 16'h1234);
    enable = 1'b0;
    tick(); tick(); tick();
    chk("stall_daddr", {24'b0, d_addr}, 8'h05);
    chk("stall_dout", {16'b0, d_dataout}, 16'h1234);
    enable = 1'b1;
    #1;
    chk("resume_we", {31'b0, d_we}, 1);
    run(10, 0);
    chk("we_count", we_cnt, 1);
    chk("st_mem", {16'b0, dmem[5]}, 16'h1234);
    end_checks();

    // HALT drains older work, holds pc, restart resumes there
    init_mem();
    set_mem(2, 16'h00AB);
    imem[0] = enc(T_LOAD, 3'd1, 3'd0, 4'd2);
    imem[4] = enc(T_ADD, 3'd3, 3'd1, 4'd1);
    imem[5] = {T_HALT, 11'b0};
    imem[7] = enc(T_STORE, 3'd3, 3'd0, 4'd11);
    imem[8] = {T_HALT, 11'b0};
    do_reset();
    model_run(8'd0, pe);
    pulse_start();
    run(20, 0);
    chk("halt_pc", {24'b0, i_addr}, {24'b0, pe});
    run(5, 0);
    chk("halt_hold", {24'b0, i_addr}, {24'b0, pe});
    chk("halt_nowe", we_cnt, 0);
    model_run(pe, pe2);
    pulse_start();
    chk("resume_pc", {24'b0, i_addr}, {24'b0, pe});
    run(20, 0);
    chk("halt_add", {16'b0, dmem[11]}, 16'h0156);
    chk("halt_pc2", {24'b0, i_addr}, {24'b0, pe2});
    end_checks();

    // Reset while a store is in EX
    init_mem();
    set_mem(2, 16'h00AB); set_mem(1, 16'h3C00);
    imem[0] = enc(T_LOAD, 3'd1, 3'd0, 4'd2);
    imem[1] = enc(T_LOAD, 3'd2, 3'd0, 4'd1);
    imem[5] = enc(T_STORE, 3'd1, 3'd0, 4'd6);
    imem[6] = {T_HALT, 11'b0};
    do_reset();
    pulse_start();
    repeat (7) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    run(10, 0);
    chk("rst_nowe", we_cnt, 0);
    chk("rst_idle", {24'b0, i_addr}, 0);
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    for (int k = 0; k < 8; k++) imem[k] = enc(T_STORE, 3'(k), 3'd0, 4'(k));
    imem[8] = {T_HALT, 11'b0};
    model_run(8'd0, pe);
    pulse_start();
    run(20, 0);
    chk("rst_gr1", {16'b0, dmem[1]}, 0);
    chk("rst_gr2", {16'b0, dmem[2]}, 0);
    end_checks();

    // ADDI wrap and pc wrap
    init_mem();
    set_mem(4, 16'hFFFF);
    imem[0] = enc(T_LOAD, 3'd1, 3'd0, 4'd4);
    imem[4] = {T_ADDI, 3'd1, 8'h01};
    imem[8] = enc(T_STORE, 3'd1, 3'd0, 4'd12);
    imem[9] = {T_HALT, 11'b0};
    do_reset();
    model_run(8'd0, pe);
    pulse_start();
    run(20, 0);
    chk("addi_wrap", {16'b0, dmem[12]}, 16'h0000);
    end_checks();
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    do_reset();
    pulse_start();
    repeat (255) tick();
    chk("pc_ff", {24'b0, i_addr}, 8'hFF);
    tick();
    chk("pc_wrap", {24'b0, i_addr}, 8'h00);

    // Random programs with random enable stalls
    for (int t = 0; t < 6; t++) begin
      init_mem();
      p = 0;
      for (int k = 0; k < 12; k++) begin
        op = OPS[$urandom_range(0, 11)];
        if (op == T_ADDI)
          ir = {op, 3'($urandom()), 8'($urandom())};
        else if (op == T_ADD || op == T_SUB || op == T_AND || op == T_OR || op == T_XOR)
          ir = enc(op, 3'($urandom()), 3'($urandom()), {1'b0, 3'($urandom())});
        else
          ir = enc(op, 3'($urandom()), 3'($urandom()), 4'($urandom()));
        imem[p] = ir;
        p += 4;
      end
      for (int k = 0; k < 8; k++) begin
        imem[p] = enc(T_STORE, 3'(k), 3'd0, 4'(k));
        p++;
      end
      imem[p] = {T_HALT, 11'b0};
      do_reset();
      model_run(8'd0, pe);
      pulse_start();
      run(160, 1);
      chk("rand_pc", {24'b0, i_addr}, {24'b0, pe});
      end_checks();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
